// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling ratio
// and the parity helper used by both transmitter and receiver.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned PAR_MAX_W      = 32;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } rx_state_e;

   // Returns the parity bit a transmitter appends; zero-extended data is harmless.
   function automatic logic parity_calc(input logic [PAR_MAX_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module uart_bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver on the system clock: start, D_WIDTH data bits LSB first,
// optional parity, one stop bit. Bits are sampled mid-period on os_tick enables.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned D_WIDTH    = 8,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               os_tick,
   input  logic               RxD,
   output logic [D_WIDTH-1:0] Rx_Data,
   output logic               valid_rx,
   output logic               parity_error,
   output logic               stop_error,
   output logic               busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(D_WIDTH + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(D_WIDTH - 1);

   rx_state_e          r_state;
   rx_state_e          w_state_d;
   logic               w_line;
   logic [TW-1:0]      r_tick_cnt;
   logic [BW-1:0]      r_bit_cnt;
   logic [D_WIDTH-1:0] r_shift;
   logic               r_par_bit;
   logic [D_WIDTH-1:0] r_rx_data;
   logic               r_valid;
   logic               r_par_err;
   logic               r_stop_err;
   logic               w_tick_mid;
   logic               w_tick_end;
   logic               w_tick_clr;
   logic               w_tick_inc;
   logic               w_sample_data;
   logic               w_sample_par;
   logic               w_finish;
   logic               w_par_err;

   uart_bit_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (RxD),
      .o_q (w_line)
   );

   assign w_tick_mid = (r_tick_cnt == TICK_MID);
   assign w_tick_end = (r_tick_cnt == TICK_END);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      if (os_tick) begin
         case (r_state)
            StIdle: begin
               if (!w_line) w_state_d = StStart;
            end
            StStart: begin
               // A line back high at mid start bit was only a glitch.
               if (w_tick_mid) w_state_d = w_line ? StIdle : StData;
            end
            StData: begin
               if (w_tick_end && (r_bit_cnt == BIT_LAST)) begin
                  if (PARITY_EN) w_state_d = StParity;
                  else           w_state_d = StStop;
               end
            end
            StParity: begin
               if (w_tick_end) w_state_d = StStop;
            end
            StStop: begin
               if (w_tick_end) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      w_tick_clr    = 1'b0;
      w_tick_inc    = 1'b0;
      w_sample_data = 1'b0;
      w_sample_par  = 1'b0;
      w_finish      = 1'b0;
      if (os_tick) begin
         case (r_state)
            StStart: begin
               w_tick_clr = w_tick_mid;
               w_tick_inc = !w_tick_mid;
            end
            StData: begin
               w_tick_clr    = w_tick_end;
               w_tick_inc    = !w_tick_end;
               w_sample_data = w_tick_end;
            end
            StParity: begin
               w_tick_clr   = w_tick_end;
               w_tick_inc   = !w_tick_end;
               w_sample_par = w_tick_end;
            end
            StStop: begin
               w_tick_clr = w_tick_end;
               w_tick_inc = !w_tick_end;
               w_finish   = w_tick_end;
            end
            default: w_tick_clr = 1'b1;
         endcase
      end
   end

   assign w_par_err = PARITY_EN ? (parity_calc(PAR_MAX_W'(r_shift), PARITY_ODD) ^ r_par_bit)
                                : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_rx_data  <= '0;
         r_valid    <= 1'b0;
         r_par_err  <= 1'b0;
         r_stop_err <= 1'b0;
      end else begin
         r_valid <= w_finish;
         if (w_tick_clr) begin
            r_tick_cnt <= '0;
         end else if (w_tick_inc) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
         end
         if (r_state == StStart) begin
            r_bit_cnt <= '0;
         end else if (w_sample_data) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end
         // Right shift so the first bit on the wire lands in bit 0.
         if (w_sample_data) r_shift <= {w_line, r_shift[D_WIDTH-1:1]};
         if (w_sample_par)  r_par_bit <= w_line;
         if (w_finish) begin
            r_rx_data  <= r_shift;
            r_stop_err <= ~w_line;
            r_par_err  <= w_par_err;
         end
      end
   end

   assign Rx_Data      = r_rx_data;
   assign valid_rx     = r_valid;
   assign parity_error = r_par_err;
   assign stop_error   = r_stop_err;
   assign busy         = (r_state != StIdle);

endmodule
